// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared constants, state encodings and the word-assembly helper for
//          the instruction-memory boot loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  localparam int c_CNT_W   = 16;
  localparam int c_STATE_W = 3;

  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_HDR0 = 3'd0;
  localparam state_t c_ST_HDR1 = 3'd1;
  localparam state_t c_ST_DATA = 3'd2;
  localparam state_t c_ST_DONE = 3'd3;
  localparam state_t c_ST_ERR  = 3'd4;

  // The three earlier bytes sit in the low 24 bits, oldest byte lowest.
  function automatic logic [31:0] assemble_word(input logic [23:0] low_bytes,
                                                input logic [7:0]  top_byte);
    return {top_byte, low_bytes};
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module : imem_loader_if
// Brief  : Byte-stream input and IMEM write bus of the boot loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: the stream source that also observes the IMEM writes; slave: the loader.
  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Boot-time IMEM writer. Takes a 16-bit LE word count plus 4*N bytes,
//          writes LE 32-bit words to 0..N-1 and holds the core in reset until
//          the final word lands. The integrator ORs core_reset with reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   bus,
  input  logic           reload,
  output logic           core_reset,
  output logic           done,
  output logic           err
);

  localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W+1)'(1) << ADDR_W;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = (c_CNT_W)'(1);

  state_t              state_q, state_d;
  logic                s_ready_q, s_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [c_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [c_CNT_W-1:0]  n_q, n_d;
  logic [23:0]         sr_q, sr_d;

  logic                w_hs;
  logic [c_CNT_W-1:0]  w_n_hdr;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic                w_word_end;
  logic                w_last_word;

  assign w_hs        = bus.s_valid & s_ready_q;
  assign w_n_hdr     = {bus.s_data, n_q[7:0]};
  assign w_cnt_inc   = word_cnt_q + c_CNT_ONE;
  assign w_word_end  = w_hs && (state_q == c_ST_DATA) && (byte_idx_q == 2'd3);
  assign w_last_word = (w_cnt_inc == n_q);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_HDR0: begin
        if (w_hs) state_d = c_ST_HDR1;
      end
      c_ST_HDR1: begin
        if (w_hs) begin
          if (w_n_hdr == '0) begin
            state_d = c_ST_DONE;
          end else if ({1'b0, w_n_hdr} > c_DEPTH) begin
            state_d = c_ST_ERR;
          end else begin
            state_d = c_ST_DATA;
          end
        end
      end
      c_ST_DATA: begin
        // Entering DONE together with the final write drops s_ready at once.
        if (w_word_end && w_last_word) state_d = c_ST_DONE;
      end
      c_ST_DONE, c_ST_ERR: begin
        if (reload) state_d = c_ST_HDR0;
      end
      default: state_d = c_ST_HDR0;
    endcase
  end

  // ----------------------------------------------------------- output decode
  always_comb begin
    s_ready_d    = (state_d == c_ST_HDR0) || (state_d == c_ST_HDR1) ||
                   (state_d == c_ST_DATA);
    // The cycle holding the final write is still "not done"; release follows it.
    done_d       = (state_q == c_ST_DONE) && (state_d == c_ST_DONE);
    core_reset_d = ~done_d;
    err_d        = (state_d == c_ST_ERR);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    n_d          = n_q;
    sr_d         = sr_q;
    case (state_q)
      c_ST_HDR0: begin
        if (w_hs) n_d = {n_q[c_CNT_W-1:8], bus.s_data};
      end
      c_ST_HDR1: begin
        if (w_hs) begin
          n_d        = w_n_hdr;
          byte_idx_d = 2'd0;
          word_cnt_d = '0;
        end
      end
      c_ST_DATA: begin
        if (w_hs) begin
          sr_d       = {bus.s_data, sr_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
        end
        if (w_word_end) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = assemble_word(sr_q, bus.s_data);
          imem_addr_d  = word_cnt_q[ADDR_W-1:0];
          word_cnt_d   = w_cnt_inc;
        end
      end
      c_ST_DONE, c_ST_ERR: begin
        if (reload) begin
          byte_idx_d = 2'd0;
          word_cnt_d = '0;
          n_d        = '0;
          sr_d       = '0;
        end
      end
      default: begin
        byte_idx_d = 2'd0;
        word_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------- output/data regs
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_idx_q   <= 2'd0;
      word_cnt_q   <= '0;
      n_q          <= '0;
      sr_q         <= '0;
    end else begin
      s_ready_q    <= s_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      n_q          <= n_d;
      sr_q         <= sr_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Directed scoreboard bench for imem_loader (ADDR_W=4, DEPTH=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic core_reset;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .reload     (reload),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_we     = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: every IMEM write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      logic [AW+31:0] e;
      n_we++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, required no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(e[AW+31:32]));
        check("write_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.s_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: s_ready=%b, required 1", bus.s_ready);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_header(input logic [15:0] n, input int gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we0;
    logic [31:0] w;
    reset       = 1'b1;
    reload      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_s_ready",    32'(bus.s_ready),  32'd0);
    check("rst_imem_we",    32'(bus.imem_we),  32'd0);
    check("rst_imem_addr",  32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", bus.imem_wdata,    32'd0);
    check("rst_core_reset", 32'(core_reset),   32'd1);
    check("rst_done",       32'(done),         32'd0);
    check("rst_err",        32'(err),          32'd0);
    reset = 1'b0;

    // Two words, no stalls; exact release timing
    we0 = n_we;
    expect_write(4'd0, 32'h00A00513);
    expect_write(4'd1, 32'h00B00593);
    send_header(16'd2, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h05, 0); send_byte(8'hB0, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check("t1_we_final",      32'(bus.imem_we), 32'd1);
    check("t1_done_at_write", 32'(done),        32'd0);
    check("t1_crst_at_write", 32'(core_reset),  32'd1);
    check("t1_ready_at_write",32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("t1_done",       32'(done),        32'd1);
    check("t1_core_reset", 32'(core_reset),  32'd0);
    check("t1_we_low",     32'(bus.imem_we), 32'd0);
    check("t1_we_count",   32'(n_we - we0),  32'd2);

    // Same stream with 3-cycle stalls between bytes
    pulse_reload();
    check("t2_reload_done", 32'(done),       32'd0);
    check("t2_reload_crst", 32'(core_reset), 32'd1);
    we0 = n_we;
    expect_write(4'd0, 32'h00A00513);
    expect_write(4'd1, 32'h00B00593);
    send_header(16'd2, 3);
    send_word(32'h00A00513, 3);
    send_word(32'h00B00593, 3);
    @(negedge clk);
    check("t2_done",     32'(done),       32'd1);
    check("t2_we_count", 32'(n_we - we0), 32'd2);

    // Empty image
    pulse_reload();
    we0 = n_we;
    send_header(16'd0, 0);
    @(negedge clk);
    check("t3_crst_hold", 32'(core_reset), 32'd1);
    check("t3_ready_low", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("t3_crst_fall", 32'(core_reset), 32'd0);
    check("t3_done",      32'(done),       32'd1);
    check("t3_we_count",  32'(n_we - we0), 32'd0);

    // Oversize header N=17 > DEPTH=16, then recovery through reload
    pulse_reload();
    send_header(16'd17, 0);
    @(negedge clk);
    check("t4_err",       32'(err),         32'd1);
    check("t4_crst",      32'(core_reset),  32'd1);
    check("t4_ready_low", 32'(bus.s_ready), 32'd0);
    pulse_reload();
    check("t4_err_clear", 32'(err),         32'd0);
    check("t4_crst_hold", 32'(core_reset),  32'd1);
    check("t4_ready_up",  32'(bus.s_ready), 32'd1);
    expect_write(4'd0, 32'hDEADBEEF);
    send_header(16'd1, 0);
    send_word(32'hDEADBEEF, 0);
    repeat (2) @(negedge clk);
    check("t4_done", 32'(done), 32'd1);

    // Reset after 6 of 8 data bytes
    pulse_reload();
    we0 = n_we;
    expect_write(4'd0, 32'h11223344);
    send_header(16'd2, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_crst",  32'(core_reset),  32'd1);
    check("t5_rst_ready", 32'(bus.s_ready), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_we_count", 32'(n_we - we0), 32'd1);
    check("t5_ready_up", 32'(bus.s_ready), 32'd1);
    expect_write(4'd0, 32'hCAFEF00D);
    send_header(16'd1, 0);
    send_word(32'hCAFEF00D, 0);
    repeat (2) @(negedge clk);
    check("t5_done", 32'(done), 32'd1);

    // Full capacity N=DEPTH=16
    pulse_reload();
    we0 = n_we;
    send_header(16'd16, 0);
    for (int i = 0; i < 16; i++) begin
      w = 32'hA0000000 | (32'(i) << 16) | 32'(i * 3);
      expect_write(AW'(i), w);
      send_word(w, 0);
    end
    @(negedge clk);
    check("t6_last_addr", 32'(bus.imem_addr), 32'd15);
    @(negedge clk);
    check("t6_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_addr_hold", 32'(bus.imem_addr), 32'd15);
    check("t6_we_count",  32'(n_we - we0),    32'd16);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
